pulse_edge_tx: RTL and testbench
================================

PULSE_EDGE_TX -- requirements
Module: pulse_edge_tx

Interface
REQ-001 Parameter HOLD_CYC, default 3: minimum cycles out_line is held at each level after every transition; supported range 2..255.
REQ-002 Parameter TOGGLE, default 0: 0 = pulse mode (each event is one rising then one falling edge); 1 = toggle mode (each event is one transition).
REQ-003 Parameter CNT_W, default 4: width of the pending-event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 evt  input  1  event request; every cycle with evt=1 is one event.
REQ-007 ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 out_line  output  1  registered line driven toward an asynchronous receiver (2-flop sync plus edge detect).
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 done  output  1  single-cycle pulse when an event's final hold phase completes.
REQ-011 pend_cnt  output  CNT_W  events accepted but not yet launched.
REQ-012 overflow  output  1  sticky; set when an event is dropped.

Function
REQ-013 FSM states SHALL be IDLE, ASSERT and DEASSERT in pulse mode, and IDLE and HOLD in toggle mode; hold counter hc counts 0..HOLD_CYC-1 inside each non-IDLE state.
REQ-014 Launch window W SHALL be true in IDLE, or in DEASSERT (pulse mode) / HOLD (toggle mode) when hc = HOLD_CYC-1.
REQ-015 Launch L = W and (evt or pend_cnt != 0).
REQ-016 On L in pulse mode: next state ASSERT, hc=0, out_line=1 on the following cycle; in toggle mode: next state HOLD, hc=0, out_line inverts on the following cycle.
REQ-017 ASSERT with hc = HOLD_CYC-1 SHALL go to DEASSERT, hc=0, out_line=0; otherwise hc increments.
REQ-018 DEASSERT/HOLD with hc = HOLD_CYC-1 and no L SHALL go to IDLE; out_line unchanged.
REQ-019 done SHALL be 1 for exactly the cycle following any DEASSERT/HOLD cycle with hc = HOLD_CYC-1, whether or not L occurs.
REQ-020 Latency: evt in IDLE with pend_cnt=0 -> out_line changes on the next clock edge (1 cycle); pend_cnt stays 0.
REQ-021 Back-to-back: with pending events, pulse mode SHALL produce a continuous stream of period 2*HOLD_CYC (HOLD_CYC high, HOLD_CYC low); toggle mode one transition every HOLD_CYC cycles.
REQ-022 pend_cnt_next = pend_cnt + evt - L, unsigned; evt and L in the same cycle leave pend_cnt unchanged.
REQ-023 When pend_cnt = 2^CNT_W-1, evt=1 and L=0, the event SHALL be dropped, pend_cnt held, overflow set.
REQ-024 overflow SHALL clear on ovf_clr=1; simultaneous set and ovf_clr SHALL leave overflow=1 (set wins).
REQ-025 pend_cnt SHALL never wrap below 0 or above 2^CNT_W-1.
REQ-026 busy SHALL be a registered decode of state (0 only in IDLE).

Reset
REQ-027 While rst=1, immediately and independent of clk: state IDLE, hc=0, out_line=0, busy=0, done=0, pend_cnt=0, overflow=0.
REQ-028 Reset asserted mid-pulse SHALL force out_line=0 at once and discard all pending events; no done pulse is generated for the aborted event.
REQ-029 First rising clk edge after rst deasserts SHALL treat evt normally (launch possible on that edge).

Verification
REQ-030 Pulse mode, HOLD_CYC=3, single evt at cycle 10 -> out_line=1 at cycles 11-13 and 0 from 14; done=1 at cycle 17 only; busy=1 at 11-16.
REQ-031 Pulse mode, HOLD_CYC=3, evt high at cycles 10-14 (5 events) -> pend_cnt peaks at 4; 5 pulses of period 6 with no gaps; done=1 at cycles 17, 23, 29, 35, 41; pend_cnt=0 from cycle 35.
REQ-032 CNT_W=2, evt held high 10 cycles -> pend_cnt saturates at 3, overflow=1; ovf_clr pulsed on the same cycle as a further drop -> overflow remains 1.
REQ-033 Toggle mode, HOLD_CYC=2, 3 evts in consecutive cycles -> out_line toggles at cycles +1, +3 and +5 relative to the first evt; final level is 1.
REQ-034 rst asserted asynchronously while out_line=1 with pend_cnt=2 -> out_line, pend_cnt and busy are 0 before the next clk edge; no done pulse.
REQ-035 Loopback: out_line into a 2-flop synchronizer plus edge detector on an unrelated clock up to 1.5x slower -> receiver edge count equals the transmitted event count.

Source files
------------

// File: rtl/pulse_edge_tx.sv
// Pulse/toggle line transmitter with a pending-event counter. Every transition on
// out_line is held for at least HOLD_CYC cycles so a slower synchronizing receiver sees it.
module pulse_edge_tx #(
    parameter int HOLD_CYC = 3,
    parameter bit TOGGLE   = 1'b0,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt,
    input  logic             ovf_clr,
    output logic             out_line,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        DEASSERT,
        HOLD
    } state_t;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] PEND_MAX  = '1;

    state_t     state;
    logic [7:0] hc;
    logic       last_hold;
    logic       launch;
    logic       drop;

    // The final cycle of the low/hold phase doubles as a launch slot, which is
    // what makes back-to-back pulses gapless.
    always_comb begin
        last_hold = 1'b0;
        launch    = 1'b0;
        drop      = 1'b0;
        if ((state == DEASSERT || state == HOLD) && hc == HOLD_LAST) begin
            last_hold = 1'b1;
        end
        if ((state == IDLE || last_hold) && (evt || pend_cnt != '0)) begin
            launch = 1'b1;
        end
        if (evt && !launch && pend_cnt == PEND_MAX) begin
            drop = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hc       <= '0;
            out_line <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_hold;
            if (launch) begin
                state    <= TOGGLE ? HOLD : ASSERT;
                busy     <= 1'b1;
                hc       <= '0;
                out_line <= TOGGLE ? ~out_line : 1'b1;
            end else begin
                case (state)
                    ASSERT: begin
                        if (hc == HOLD_LAST) begin
                            state    <= DEASSERT;
                            hc       <= '0;
                            out_line <= 1'b0;
                        end else begin
                            hc <= hc + 8'd1;
                        end
                    end
                    DEASSERT, HOLD: begin
                        if (hc == HOLD_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            hc    <= '0;
                        end else begin
                            hc <= hc + 8'd1;
                        end
                    end
                    default: begin
                        hc <= '0;
                    end
                endcase
            end
        end
    end

    // Counter saturates: a full queue drops the event instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (evt && !launch && !drop) begin
                pend_cnt <= pend_cnt + 1'b1;
            end else if (!evt && launch) begin
                pend_cnt <= pend_cnt - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_edge_tx.sv
// Self-checking bench for pulse_edge_tx: pulse mode, small-counter overflow,
// toggle mode, asynchronous reset and a slow-clock loopback receiver.
module tb_pulse_edge_tx;

    logic clk = 1'b0;
    logic rx_clk = 1'b0;
    logic rst = 1'b0;

    logic       evt_a = 1'b0, clr_a = 1'b0;
    logic       out_a, busy_a, done_a, ovf_a;
    logic [3:0] pend_a;

    logic       evt_b = 1'b0, clr_b = 1'b0;
    logic       out_b, busy_b, done_b, ovf_b;
    logic [1:0] pend_b;

    logic       evt_c = 1'b0, clr_c = 1'b0;
    logic       out_c, busy_c, done_c, ovf_c;
    logic [3:0] pend_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;
    always #15 rx_clk = ~rx_clk;

    pulse_edge_tx #(.HOLD_CYC(3), .TOGGLE(1'b0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .evt(evt_a), .ovf_clr(clr_a),
        .out_line(out_a), .busy(busy_a), .done(done_a),
        .pend_cnt(pend_a), .overflow(ovf_a)
    );

    pulse_edge_tx #(.HOLD_CYC(3), .TOGGLE(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .evt(evt_b), .ovf_clr(clr_b),
        .out_line(out_b), .busy(busy_b), .done(done_b),
        .pend_cnt(pend_b), .overflow(ovf_b)
    );

    pulse_edge_tx #(.HOLD_CYC(2), .TOGGLE(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .evt(evt_c), .ovf_clr(clr_c),
        .out_line(out_c), .busy(busy_c), .done(done_c),
        .pend_cnt(pend_c), .overflow(ovf_c)
    );

    // Loopback receiver: 2-flop synchronizer plus rising-edge detect on a 1.5x slower clock.
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    int   rx_edges = 0;
    always @(posedge rx_clk) begin
        s1 <= out_a;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) rx_edges <= rx_edges + 1;
    end

    typedef struct {
        int         n;
        logic       evt;
        logic       out;
        logic       busy;
        logic       done;
        logic [3:0] pend;
    } seg_t;

    seg_t segs[$];

    function automatic void addSeg(int n, logic e, logic o, logic b, logic d, logic [3:0] p);
        seg_t s;
        s.n    = n;
        s.evt  = e;
        s.out  = o;
        s.busy = b;
        s.done = d;
        s.pend = p;
        segs.push_back(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic e, input logic c);
        case (which)
            0: begin evt_a = e; clr_a = c; end
            1: begin evt_b = e; clr_b = c; end
            default: begin evt_c = e; clr_c = c; end
        endcase
    endtask

    task automatic checkOutput(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic waitIdleA(input int budget, input string name);
        int k = 0;
        while ((busy_a || pend_a != 4'd0) && k < budget) begin
            step();
            k++;
        end
        checkOutput(name, int'(k < budget), 1);
    endtask

    initial begin
        logic [8:0]  tog_out;
        logic [8:0]  tog_done;
        logic [11:0] lb_pat;
        int          tx_cnt;
        int          base;
        int          k;

        // Single pulse: evt at cycle 10 (n, evt, out, busy, done, pend)
        addSeg(10, 0, 0, 0, 0, 0);
        addSeg(1,  1, 0, 0, 0, 0);
        addSeg(3,  0, 1, 1, 0, 0);
        addSeg(3,  0, 0, 1, 0, 0);
        addSeg(1,  0, 0, 0, 1, 0);
        addSeg(2,  0, 0, 0, 0, 0);
        // Burst of five: evt at relative cycles 10..14
        addSeg(10, 0, 0, 0, 0, 0);
        addSeg(1,  1, 0, 0, 0, 0);
        addSeg(1,  1, 1, 1, 0, 0);
        addSeg(1,  1, 1, 1, 0, 1);
        addSeg(1,  1, 1, 1, 0, 2);
        addSeg(1,  1, 0, 1, 0, 3);
        addSeg(2,  0, 0, 1, 0, 4);
        addSeg(1,  0, 1, 1, 1, 3);
        addSeg(2,  0, 1, 1, 0, 3);
        addSeg(3,  0, 0, 1, 0, 3);
        addSeg(1,  0, 1, 1, 1, 2);
        addSeg(2,  0, 1, 1, 0, 2);
        addSeg(3,  0, 0, 1, 0, 2);
        addSeg(1,  0, 1, 1, 1, 1);
        addSeg(2,  0, 1, 1, 0, 1);
        addSeg(3,  0, 0, 1, 0, 1);
        addSeg(1,  0, 1, 1, 1, 0);
        addSeg(2,  0, 1, 1, 0, 0);
        addSeg(3,  0, 0, 1, 0, 0);
        addSeg(1,  0, 0, 0, 1, 0);
        addSeg(2,  0, 0, 0, 0, 0);

        #1 rst = 1'b1;
        #2;
        checkOutput("rst_out",  int'(out_a),  0);
        checkOutput("rst_busy", int'(busy_a), 0);
        checkOutput("rst_done", int'(done_a), 0);
        checkOutput("rst_pend", int'(pend_a), 0);
        checkOutput("rst_ovf",  int'(ovf_a),  0);
        checkOutput("rst_outc", int'(out_c),  0);
        step();
        rst = 1'b0;

        for (int i = 0; i < segs.size(); i++) begin
            for (int j = 0; j < segs[i].n; j++) begin
                applyStimulus(0, segs[i].evt, 1'b0);
                checkOutput($sformatf("seg%0d_out", i),  int'(out_a),  int'(segs[i].out));
                checkOutput($sformatf("seg%0d_busy", i), int'(busy_a), int'(segs[i].busy));
                checkOutput($sformatf("seg%0d_done", i), int'(done_a), int'(segs[i].done));
                checkOutput($sformatf("seg%0d_pend", i), int'(pend_a), int'(segs[i].pend));
                checkOutput($sformatf("seg%0d_ovf", i),  int'(ovf_a),  0);
                step();
            end
        end
        applyStimulus(0, 1'b0, 1'b0);

        // Overflow on the 2-bit counter, then ovf_clr colliding with a drop
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 1'b1, 1'b0);
            if (c == 4) begin
                checkOutput("ovfb_c4_pend", int'(pend_b), 3);
                checkOutput("ovfb_c4_ovf",  int'(ovf_b),  0);
            end
            if (c == 5) checkOutput("ovfb_c5_ovf", int'(ovf_b), 1);
            if (c == 9) checkOutput("ovfb_c9_pend", int'(pend_b), 3);
            step();
        end
        applyStimulus(1, 1'b1, 1'b1);
        step();
        checkOutput("ovfb_setwins_ovf",  int'(ovf_b),  1);
        checkOutput("ovfb_setwins_pend", int'(pend_b), 3);
        applyStimulus(1, 1'b0, 1'b1);
        step();
        checkOutput("ovfb_clr_ovf", int'(ovf_b), 0);
        applyStimulus(1, 1'b0, 1'b0);
        k = 0;
        while ((busy_b || pend_b != 2'd0) && k < 100) begin
            step();
            k++;
        end
        checkOutput("ovfb_drain_timeout", int'(k < 100), 1);
        step();
        checkOutput("ovfb_drain_pend", int'(pend_b), 0);

        // Toggle mode, HOLD_CYC=2, three consecutive events
        tog_out  = 9'b111100110;
        tog_done = 9'b010101000;
        for (int t = 0; t < 9; t++) begin
            applyStimulus(2, t < 3, 1'b0);
            checkOutput($sformatf("tog_out_t%0d", t),  int'(out_c),  int'(tog_out[t]));
            checkOutput($sformatf("tog_done_t%0d", t), int'(done_c), int'(tog_done[t]));
            step();
        end

        // Asynchronous reset mid-pulse with two events queued
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1'b1, 1'b0);
            step();
        end
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("arst_pre_out",  int'(out_a),  1);
        checkOutput("arst_pre_pend", int'(pend_a), 2);
        #5 rst = 1'b1;
        #1;
        checkOutput("arst_out",  int'(out_a),  0);
        checkOutput("arst_pend", int'(pend_a), 0);
        checkOutput("arst_busy", int'(busy_a), 0);
        step();
        checkOutput("arst_done", int'(done_a), 0);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 1'b0);
        step();
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("rel_launch_out",  int'(out_a),  1);
        checkOutput("rel_launch_busy", int'(busy_a), 1);
        checkOutput("rel_launch_done", int'(done_a), 0);
        checkOutput("rel_launch_pend", int'(pend_a), 0);
        waitIdleA(50, "rel_idle_timeout");

        // Loopback through the slow receiver
        repeat (4) @(posedge rx_clk);
        #1;
        base   = rx_edges;
        lb_pat = 12'b1011_0011_1101;
        tx_cnt = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            applyStimulus(0, lb_pat[t], 1'b0);
            if (lb_pat[t]) tx_cnt++;
        end
        step();
        applyStimulus(0, 1'b0, 1'b0);
        waitIdleA(300, "loop_idle_timeout");
        repeat (5) @(posedge rx_clk);
        #1;
        checkOutput("loop_edges", rx_edges - base, tx_cnt);
        checkOutput("loop_edges_expected8", rx_edges - base, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
